// File: rtl/transport_grant_arbiter.sv
// transport_grant_arbiter: bus/train grant arbiter gated by transport, one-hot grants, guard gap; ARB_HOLD_LIMIT_EN adds forced handover after MAX_HOLD cycles
module transport_grant_arbiter #(
    parameter int GAP_CYCLES = 1,
    parameter int MAX_HOLD   = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             transport,
    input  logic             bus_req,
    input  logic             train_req,
    output logic             bus,
    output logic             train,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt
);
    typedef enum logic [1:0] {IDLE, BUS_GNT, TRAIN_GNT, GAP} state_t;

    state_t           state_q, state_d;
    logic             bus_q, train_q, busy_q;
    logic             last_train_q, last_train_d;
    logic [3:0]       gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             own_req, oth_req, handover, pick_train;

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
        $error("transport_grant_arbiter: parameter out of range");
    end

    assign own_req    = (state_q == TRAIN_GNT) ? train_req : bus_req;
    assign oth_req    = (state_q == TRAIN_GNT) ? bus_req : train_req;
    assign pick_train = train_req && (!bus_req || !last_train_q);

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold_q, hold_d;

    assign handover = (hold_q == 8'(MAX_HOLD)) && oth_req;
    assign hold_d   = (state_d != state_q) ? 8'd1 : (hold_q == 8'(MAX_HOLD)) ? hold_q : hold_q + 8'd1;

    // hold counter restarts on every state change and saturates at MAX_HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
`else
    assign handover = 1'b0;
`endif

    // next-state: arbitrate in IDLE, release on request/transport loss, time the guard gap
    always_comb begin
        state_d      = state_q;
        last_train_d = last_train_q;
        gap_d        = gap_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (transport && (bus_req || train_req)) begin
                    state_d      = pick_train ? TRAIN_GNT : BUS_GNT;
                    last_train_d = pick_train;
                    cnt_d        = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            BUS_GNT, TRAIN_GNT: begin
                if (!own_req || !transport || handover) begin
                    state_d = GAP;
                    gap_d   = 4'd1;
                end
            end
            GAP: begin
                state_d = (gap_q >= 4'(GAP_CYCLES)) ? IDLE : GAP;
                gap_d   = (gap_q >= 4'(GAP_CYCLES)) ? gap_q : gap_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered grant/busy flags; async reset drops grants immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_q        <= 1'b0;
            train_q      <= 1'b0;
            busy_q       <= 1'b0;
            last_train_q <= 1'b1;
            gap_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            bus_q        <= (state_d == BUS_GNT);
            train_q      <= (state_d == TRAIN_GNT);
            busy_q       <= (state_d != IDLE);
            last_train_q <= last_train_d;
            gap_q        <= gap_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus       = bus_q && transport;
    assign train     = train_q && transport;
    assign busy      = busy_q;
    assign grant_cnt = cnt_q;
endmodule

// File: tb/tb_transport_grant_arbiter.sv
// tb_transport_grant_arbiter: directed table-driven bench for transport_grant_arbiter
module tb_transport_grant_arbiter;
    logic       clk = 1'b0, rst = 1'b1, transport = 1'b0, bus_req = 1'b0, train_req = 1'b0;
    logic       bus, train, busy;
    logic [7:0] grant_cnt;
    int         n_chk = 0, n_pass = 0;

    typedef struct packed {
        logic       r, t, b, tr;
        logic       eb, etr, ebusy;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    transport_grant_arbiter #(.GAP_CYCLES(1), .MAX_HOLD(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .transport(transport), .bus_req(bus_req), .train_req(train_req),
        .bus(bus), .train(train), .busy(busy), .grant_cnt(grant_cnt)
    );

    // grants must never be high together in any cycle
    always @(negedge clk) begin
        n_chk++;
        if (bus && train) $display("FAIL onehot t=%0t: bus=%b train=%b, required not both high", $time, bus, train);
        else n_pass++;
    end

    task automatic check_now(input string name, input logic eb, etr, ebusy, input logic [7:0] ecnt);
        n_chk++;
        if (bus === eb && train === etr && busy === ebusy && grant_cnt === ecnt) n_pass++;
        else $display("FAIL %s: got bus=%b train=%b busy=%b cnt=%0d, required bus=%b train=%b busy=%b cnt=%0d",
                      name, bus, train, busy, grant_cnt, eb, etr, ebusy, ecnt);
    endtask

    task automatic step(input string name, input logic r, t, b, tr, eb, etr, ebusy, input logic [7:0] ecnt);
        rst = r; transport = t; bus_req = b; train_req = tr;
        @(posedge clk);
        #1;
        check_now(name, eb, etr, ebusy, ecnt);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        for (int i = 0; i < 13; i++)
            step($sformatf("vec%0d", i), vecs[i].r, vecs[i].t, vecs[i].b, vecs[i].tr,
                 vecs[i].eb, vecs[i].etr, vecs[i].ebusy, vecs[i].ecnt);

        step("t3_rst", 1, 0, 0, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 10; i++)
            step($sformatf("t3_notransport%0d", i), 0, 0, 1, 1, 0, 0, 0, 8'd0);

        step("t4_grant", 0, 1, 1, 0, 1, 0, 1, 8'd1);
        transport = 1'b0;
        #1;
        check_now("t4_mask", 0, 0, 1, 8'd1);
        step("t4_gap", 0, 0, 1, 0, 0, 0, 1, 8'd1);
        step("t4_idle", 0, 1, 1, 0, 0, 0, 0, 8'd1);
        step("t4_regrant", 0, 1, 1, 0, 1, 0, 1, 8'd2);

        step("t5_gap", 0, 1, 0, 1, 0, 0, 1, 8'd2);
        step("t5_idle", 0, 1, 0, 1, 0, 0, 0, 8'd2);
        step("t5_train", 0, 1, 0, 1, 0, 1, 1, 8'd3);
        #2;
        rst = 1'b1;
        #1;
        check_now("t5_async_rst", 0, 0, 0, 8'd0);
        step("t5_release", 0, 1, 0, 1, 0, 1, 1, 8'd1);

        step("t6_rst", 1, 0, 0, 0, 0, 0, 0, 8'd0);
        step("t6_entry", 0, 1, 1, 1, 1, 0, 1, 8'd1);
`ifdef ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 3; i++)
            step($sformatf("t6_hold%0d", i), 0, 1, 1, 1, 1, 0, 1, 8'd1);
        step("t6_gap", 0, 1, 1, 1, 0, 0, 1, 8'd1);
        step("t6_idle", 0, 1, 1, 1, 0, 0, 0, 8'd1);
        step("t6_handover", 0, 1, 1, 1, 0, 1, 1, 8'd2);
`else
        for (int i = 0; i < 19; i++)
            step($sformatf("t6_hold%0d", i), 0, 1, 1, 1, 1, 0, 1, 8'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
